// File: rtl/preg_reclaim_pkg.sv
// Shared types and helpers for physical-register reclamation.
package preg_reclaim_pkg;
    localparam int PHY_REG_NUM = 64;
    localparam int PW          = $clog2(PHY_REG_NUM);
    localparam int POP_W       = 32;

    typedef logic [PW-1:0] preg_t;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/config.svh
// Build-wide configuration shared by the rename/commit blocks.
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

// File: rtl/preg_reclaim_slot_compact.sv
// Prefix-sum packer: moves valid slots, in order, into lanes 0..count-1.
module slot_compact #(
    parameter int LANES = 4,
    parameter int W     = 6,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]        valid,
    input  logic [LANES-1:0][W-1:0] data,
    output logic [LANES-1:0]        lane_valid,
    output logic [LANES-1:0][W-1:0] lane_data,
    output logic [CW-1:0]           count
);
    logic [CW-1:0] pre [LANES];
    logic [CW-1:0] run;

    always_comb begin
        lane_valid = '0;
        lane_data  = '0;
        run        = '0;
        for (int i = 0; i < LANES; i++) begin
            pre[i] = run;
            run    = run + CW'(valid[i]);
        end
        count = run;
        // Each output lane takes the slot whose prefix count equals its index.
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < LANES; i++) begin
                if (valid[i] && pre[i] == CW'(l)) begin
                    lane_valid[l] = 1'b1;
                    lane_data[l]  = data[i];
                end
            end
        end
    end
endmodule

// File: rtl/preg_reclaim.sv
// Collects old pregs released by committing instructions and streams them
// to the free list, tracking the architectural free-list pointers.
`include "config.svh"

module preg_reclaim #(
    parameter int PHY_REG_NUM  = preg_reclaim_pkg::PHY_REG_NUM,
    parameter int COMMIT_WIDTH = `COMMIT_WIDTH,
    parameter int PW           = $clog2(PHY_REG_NUM)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic [COMMIT_WIDTH-1:0]         commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]         commit_dest_valid_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0] commit_old_preg_i,
    output logic                            commit_ready_o,
    output logic [COMMIT_WIDTH-1:0]         free_valid_o,
    output logic [COMMIT_WIDTH-1:0][PW-1:0] free_preg_o,
    input  logic                            free_ready_i,
    output logic [PW-1:0]                   arch_head_o,
    output logic [PW-1:0]                   arch_tail_o,
    output logic [PW:0]                     arch_cnt_o
);
    localparam int CNTW = $clog2(COMMIT_WIDTH + 1);

    logic                            stage_vld, accept, drain;
    logic [COMMIT_WIDTH-1:0]         rel_mask, cmp_valid;
    logic [COMMIT_WIDTH-1:0][PW-1:0] cmp_preg;
    logic [CNTW-1:0]                 d_cnt, f_cnt;
    logic [PW-1:0]                   head_q, tail_q, head_d, tail_d;
    logic [PW:0]                     cnt_q, cnt_d;

    // Flush never discards releases, so it has no effect on this block.
    logic unused_flush;
    assign unused_flush = flush_i;

    assign stage_vld      = |free_valid_o;
    assign commit_ready_o = !stage_vld || free_ready_i;
    assign accept         = !rst && (|commit_valid_i) && commit_ready_o;
    assign drain          = !rst && stage_vld && free_ready_i;
    assign rel_mask       = commit_valid_i & commit_dest_valid_i & {COMMIT_WIDTH{accept}};

    slot_compact #(.LANES(COMMIT_WIDTH), .W(PW), .CW(CNTW)) u_compact (
        .valid      (rel_mask),
        .data       (commit_old_preg_i),
        .lane_valid (cmp_valid),
        .lane_data  (cmp_preg),
        .count      (d_cnt)
    );

    assign f_cnt = drain ? CNTW'(preg_reclaim_pkg::popcount(
                       preg_reclaim_pkg::POP_W'(free_valid_o))) : '0;

    // Power-of-two index space: natural truncation gives the wrap.
    assign head_d = head_q + PW'(d_cnt);
    assign tail_d = tail_q + PW'(f_cnt);
    assign cnt_d  = cnt_q + (PW+1)'(f_cnt) - (PW+1)'(d_cnt);

    assign arch_head_o = head_d;
    assign arch_tail_o = tail_d;
    assign arch_cnt_o  = cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_valid_o <= '0;
            free_preg_o  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= (PW+1)'(PHY_REG_NUM);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (accept && d_cnt != '0) begin
                free_valid_o <= cmp_valid;
                free_preg_o  <= cmp_preg;
            end else if (drain) begin
                free_valid_o <= '0;
                free_preg_o  <= '0;
            end
        end
    end

    int cnt_next;
    assign cnt_next = int'(cnt_q) + int'(f_cnt) - int'(d_cnt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt_next >= 0 && cnt_next <= PHY_REG_NUM)
            else $error("preg_reclaim: free count out of range (%0d)", cnt_next);
        end
    end
endmodule

// File: tb/tb_preg_reclaim.sv
// Directed and scoreboard-checked stimulus for preg_reclaim (4 lanes, 64 pregs).
module tb_preg_reclaim;
    localparam int CW = 4;
    localparam int PW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [CW-1:0]     cv = '0, dv = '0;
    logic [CW-1:0][PW-1:0] old = '0;
    logic              rdy;
    logic [CW-1:0]     fv;
    logic [CW-1:0][PW-1:0] fp;
    logic              fr = 1'b1;
    logic [PW-1:0]     ah, at;
    logic [PW:0]       ac;

    int n_chk = 0;
    int n_fail = 0;

    preg_reclaim #(.PHY_REG_NUM(64), .COMMIT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush),
        .commit_valid_i      (cv),
        .commit_dest_valid_i (dv),
        .commit_old_preg_i   (old),
        .commit_ready_o      (rdy),
        .free_valid_o        (fv),
        .free_preg_o         (fp),
        .free_ready_i        (fr),
        .arch_head_o         (ah),
        .arch_tail_o         (at),
        .arch_cnt_o          (ac)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arch(input string tag, input int h, input int t, input int c);
        check({tag, "_head"}, 32'(ah), 32'(h));
        check({tag, "_tail"}, 32'(at), 32'(t));
        check({tag, "_cnt"},  32'(ac), 32'(c));
    endtask

    int sb[$];
    int m_head, m_tail, m_cnt, m_n, d, f;
    logic exp_rdy, hs, acc;

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_fv", 32'(fv), 0);
        check("rst_fp", 32'(fp), 0);
        check("rst_rdy", 32'(rdy), 1);
        arch("rst", 0, 0, 64);
        step();
        rst = 1'b0;

        // Compaction: dests in slots 1 and 3
        cv = 4'b1111; dv = 4'b1010; old = {6'd8, 6'd7, 6'd6, 6'd5};
        #1;
        check("cmp_rdy", 32'(rdy), 1);
        arch("cmp_acc", 2, 0, 62);
        step();
        cv = '0; dv = '0;
        #1;
        check("cmp_fv", 32'(fv), 32'h3);
        check("cmp_fp", 32'(fp), 32'({6'd0, 6'd0, 6'd8, 6'd6}));
        arch("cmp_hs", 2, 2, 64);
        step();
        #1;
        check("cmp_clr", 32'(fv), 0);

        // Backpressure: stage held while free list stalls
        fr = 1'b0; cv = 4'b0011; dv = 4'b0011; old = {6'd0, 6'd0, 6'd11, 6'd10};
        #1;
        arch("bp_acc", 4, 2, 62);
        step();
        cv = 4'b1111; dv = 4'b1111; old = {6'd23, 6'd22, 6'd21, 6'd20};
        repeat (3) begin
            #1;
            check("bp_rdy", 32'(rdy), 0);
            check("bp_fv", 32'(fv), 32'h3);
            check("bp_fp", 32'(fp), 32'({6'd0, 6'd0, 6'd11, 6'd10}));
            arch("bp_hold", 4, 2, 62);
            step();
        end
        fr = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(rdy), 1);
        arch("bp_both", 8, 4, 60);
        step();
        cv = '0; dv = '0;
        #1;
        check("bp_fv2", 32'(fv), 32'hF);
        check("bp_fp2", 32'(fp), 32'({6'd23, 6'd22, 6'd21, 6'd20}));
        arch("bp_drain", 8, 8, 64);
        step();
        #1;
        check("bp_clr", 32'(fv), 0);

        // Back-to-back streaming up to head 62
        for (int k = 0; k < 13; k++) begin
            cv = 4'b1111; dv = 4'b1111;
            old = {6'(k + 3), 6'(k + 2), 6'(k + 1), 6'(k)};
            #1;
            check("stream_rdy", 32'(rdy), 1);
            step();
        end
        cv = 4'b0011; dv = 4'b0011;
        #1;
        check("stream_last_rdy", 32'(rdy), 1);
        step();
        cv = '0; dv = '0;
        #1;
        arch("stream_end", 62, 62, 64);
        step();

        // Head wrap 62 + 4 -> 2
        cv = 4'b1111; dv = 4'b1111; old = {6'd43, 6'd42, 6'd41, 6'd40};
        #1;
        arch("wrap_head", 2, 62, 60);
        step();
        // Flush with concurrent accept and drain; tail wraps 62 + 4 -> 2
        flush = 1'b1; dv = 4'b0101; old = {6'd33, 6'd32, 6'd31, 6'd30};
        #1;
        check("fl_fv", 32'(fv), 32'hF);
        check("fl_fp", 32'(fp), 32'({6'd43, 6'd42, 6'd41, 6'd40}));
        arch("fl_arch", 4, 2, 62);
        step();
        flush = 1'b0; cv = '0; dv = '0; fr = 1'b0;
        #1;
        check("fl_pend_fv", 32'(fv), 32'h3);
        check("fl_pend_fp", 32'(fp), 32'({6'd0, 6'd0, 6'd32, 6'd30}));
        arch("fl_after", 4, 2, 62);

        // Reset with a full stage
        rst = 1'b1;
        #1;
        check("mrst_fv", 32'(fv), 0);
        check("mrst_fp", 32'(fp), 0);
        check("mrst_rdy", 32'(rdy), 1);
        arch("mrst", 0, 0, 64);
        step();
        rst = 1'b0; fr = 1'b1;

        // Random streams against a scoreboard
        m_head = 0; m_tail = 0; m_cnt = 64; m_n = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 380) begin
                cv = 4'((1 << $urandom_range(0, 4)) - 1);
                dv = 4'($urandom);
                for (int i = 0; i < CW; i++) old[i] = 6'($urandom);
                fr = ($urandom_range(0, 3) != 0);
            end else begin
                cv = '0; dv = '0; fr = 1'b1;
            end
            #1;
            exp_rdy = (m_n == 0) || fr;
            check("rnd_rdy", 32'(rdy), 32'(exp_rdy));
            check("rnd_fv", 32'(fv), 32'((1 << m_n) - 1));
            hs = (m_n != 0) && fr;
            f = hs ? m_n : 0;
            if (hs) begin
                for (int l = 0; l < m_n; l++) begin
                    if (sb.size() == 0) check("rnd_sb_underflow", 1, 0);
                    else check("rnd_lane", 32'(fp[l]), 32'(sb.pop_front()));
                end
            end
            acc = (cv != 0) && exp_rdy;
            d = 0;
            if (acc) begin
                for (int i = 0; i < CW; i++) begin
                    if (cv[i] && dv[i]) begin
                        sb.push_back(int'(old[i]));
                        d++;
                    end
                end
            end
            m_head = (m_head + d) % 64;
            m_tail = (m_tail + f) % 64;
            m_cnt  = m_cnt + f - d;
            arch("rnd", m_head, m_tail, m_cnt);
            if (acc && d > 0) m_n = d;
            else if (hs) m_n = 0;
            step();
        end
        check("rnd_sb_empty", 32'(sb.size()), 0);
        check("rnd_final_cnt", 32'(ac), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
